// File: rtl/perceptron_ctrl_pkg.sv
// Shared definitions for the perceptron UART command sequencer: state codes,
// protocol bytes and the register-file select width helper.
package perceptron_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StLoadW     = 3'd1,
    StLoadX     = 3'd2,
    StCompute   = 3'd3,
    StWaitDone  = 3'd4,
    StSend      = 3'd5,
    StSendGuard = 3'd6
  } ctrl_state_e;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_X = 8'h58;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // Width of an index addressing n inputs plus the bias word.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ctrl_timeout_counter.sv
// Loadable down-counter; expire_o pulses when an enabled count sits at zero
// and no reload is requested in the same cycle.
module ctrl_timeout_counter #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // A reload in the expiry cycle wins over the timeout.
  assign expire_o = en_i && !load_i && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/perceptron_uart_ctrl.sv
// Command sequencer between the UART byte cores and the perceptron datapath:
// loads weights/inputs, triggers a compute and returns the result byte.
module perceptron_uart_ctrl
  import perceptron_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned N_INPUTS       = 2,
  parameter int unsigned TIMEOUT_CYCLES = 12000000,
  localparam int unsigned SEL_W         = sel_width(N_INPUTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              wr_en,
  output logic              wr_weight,
  output logic [SEL_W-1:0]  wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              start,
  input  logic              done,
  input  logic [DATA_W-1:0] result,
  output logic [4:0]        cont_state
);

  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  ctrl_state_e       state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_weight_q, wr_weight_d;
  logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic              loaded_q, loaded_d;
  logic              send_ok_q, send_ok_d;
  logic              loading;
  logic              expire;

  assign loading = (state_q == StLoadW) || (state_q == StLoadX);

  ctrl_timeout_counter #(
    .CNT_W (TO_W)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (rx_valid),
    .load_val_i (TO_W'(TIMEOUT_CYCLES - 1)),
    .en_i       (loading),
    .expire_o   (expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    wr_en_d     = 1'b0;
    wr_weight_d = wr_weight_q;
    wr_sel_d    = wr_sel_q;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;
    err_d       = err_q;
    loaded_d    = loaded_q;
    send_ok_d   = send_ok_q;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          idx_d = '0;
          if (rx_data == DATA_W'(CMD_W)) begin
            state_d = StLoadW;
          end else if ((rx_data == DATA_W'(CMD_X)) && loaded_q) begin
            state_d = StLoadX;
          end else begin
            tx_data_d = DATA_W'(NAK);
            send_ok_d = 1'b0;
            err_d     = 1'b1;
            state_d   = StSend;
          end
        end
      end
      StLoadW, StLoadX: begin
        if (rx_valid) begin
          wr_en_d     = 1'b1;
          wr_weight_d = (state_q == StLoadW);
          wr_sel_d    = idx_q;
          wr_data_d   = rx_data;
          idx_d       = idx_q + 1'b1;
          if ((state_q == StLoadW) && (idx_q == SEL_W'(N_INPUTS))) begin
            loaded_d  = 1'b1;
            tx_data_d = DATA_W'(ACK);
            send_ok_d = 1'b1;
            state_d   = StSend;
          end else if ((state_q == StLoadX) && (idx_q == SEL_W'(N_INPUTS - 1))) begin
            state_d = StCompute;
          end
        end else if (expire) begin
          // A half-written weight bank can no longer be trusted.
          if (state_q == StLoadW) begin
            loaded_d = 1'b0;
          end
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCompute: begin
        start_d = 1'b1;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (done) begin
          tx_data_d = result;
          send_ok_d = 1'b1;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          if (send_ok_q) begin
            err_d = 1'b0;
          end
          state_d = StSendGuard;
        end
      end
      StSendGuard: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_weight_q <= 1'b0;
      wr_sel_q    <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      loaded_q    <= 1'b0;
      send_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      wr_en_q     <= wr_en_d;
      wr_weight_q <= wr_weight_d;
      wr_sel_q    <= wr_sel_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      err_q       <= err_d;
      loaded_q    <= loaded_d;
      send_ok_q   <= send_ok_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign wr_en      = wr_en_q;
  assign wr_weight  = wr_weight_q;
  assign wr_sel     = wr_sel_q;
  assign wr_data    = wr_data_q;
  assign start      = start_q;
  assign cont_state = {loaded_q, err_q, state_q};

endmodule

// File: tb/tb_perceptron_uart_ctrl.sv
// Scoreboard bench for perceptron_uart_ctrl: a frame-level model predicts writes,
// compute triggers and UART responses; a monitor checks them as they appear.
module tb_perceptron_uart_ctrl;

  localparam int DW = 8;
  localparam int NI = 2;
  localparam int TO = 64;
  localparam int NAK_B = 8'h15;
  localparam int ACK_B = 8'h06;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic          wr_en;
  logic          wr_weight;
  logic [1:0]    wr_sel;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          done = 1'b0;
  logic [DW-1:0] result = '0;
  logic [4:0]    cont_state;

  perceptron_uart_ctrl #(
    .DATA_W         (DW),
    .N_INPUTS       (NI),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .wr_en      (wr_en),
    .wr_weight  (wr_weight),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .start      (start),
    .done       (done),
    .result     (result),
    .cont_state (cont_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int w;
    int sel;
    int data;
  } wr_t;

  wr_t wr_q[$];
  int  tx_q[$];
  int  st_q[$];
  int  ntot = 0;
  int  npass = 0;
  int  last_tx_cyc = -1;

  bit  m_loaded = 0;
  bit  m_err = 0;

  bit  hold_busy = 0;
  int  busy_cnt = 0;
  bit  core_en = 1;
  bit  core_busy = 0;
  int  core_result = 0;
  int  done_req_n = 0;

  task automatic check(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor / scoreboard
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (wr_en || start || tx_start)
        check("one_pulse", int'(wr_en) + int'(start) + int'(tx_start), 1);
      if (wr_en) begin
        check("wr_expected", int'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          check("wr_weight", int'(wr_weight), e.w);
          check("wr_sel", int'(wr_sel), e.sel);
          check("wr_data", int'(wr_data), e.data);
        end
      end
      if (start) begin
        check("start_expected", int'(st_q.size() != 0), 1);
        if (st_q.size() != 0) check("start_cycle", cyc, st_q.pop_front());
      end
      if (tx_start) begin
        last_tx_cyc = cyc;
        check("tx_expected", int'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) check("tx_data", int'(tx_data), tx_q.pop_front());
      end
    end
  end

  // UART tx core model: busy a few cycles after each tx_start
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) busy_cnt = 4;
      else if (busy_cnt > 0) busy_cnt--;
      tx_busy = hold_busy || (busy_cnt > 0);
    end
  end

  // Perceptron core model: answers a start after a random latency
  initial begin
    int seen_n;
    bit manual;
    seen_n = 0;
    forever begin
      @(negedge clk);
      manual = (done_req_n != seen_n);
      if ((start && core_en) || manual) begin
        seen_n = done_req_n;
        core_busy = 1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        done = 1'b1;
        result = DW'(manual ? 8'h5A : core_result);
        if (!manual) tx_q.push_back(core_result);
        @(posedge clk);
        #1;
        done = 1'b0;
        core_busy = 0;
      end
    end
  end

  task automatic send_byte(input int b, input int gap, input bit push_start);
    @(posedge clk);
    #1;
    rx_data = DW'(b);
    rx_valid = 1'b1;
    if (push_start) st_q.push_back(cyc + 2);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic push_wr(input int w, input int sel, input int data);
    wr_t e;
    e.w = w;
    e.sel = sel;
    e.data = data;
    wr_q.push_back(e);
  endtask

  task automatic wait_quiet(input int extra);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while ((wr_q.size() != 0 || tx_q.size() != 0 || st_q.size() != 0 || tx_busy || core_busy)
           && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 5000) check("quiet_timeout", n, 0);
    repeat (extra) @(negedge clk);
  endtask

  task automatic check_status();
    check("cont_state", int'(cont_state), (int'(m_loaded) << 4) | (int'(m_err) << 3));
  endtask

  task automatic w_frame(input int b0, input int b1, input int b2);
    send_byte(8'h57, $urandom_range(0, 4), 0);
    push_wr(1, 0, b0);
    send_byte(b0, $urandom_range(0, 4), 0);
    push_wr(1, 1, b1);
    send_byte(b1, $urandom_range(0, 4), 0);
    push_wr(1, 2, b2);
    tx_q.push_back(ACK_B);
    send_byte(b2, 0, 0);
    m_loaded = 1;
    m_err = 0;
  endtask

  task automatic x_frame(input int x0, input int x1, input int res);
    if (!m_loaded) begin
      tx_q.push_back(NAK_B);
      send_byte(8'h58, 0, 0);
      m_err = 1;
    end else begin
      core_result = res;
      send_byte(8'h58, $urandom_range(0, 4), 0);
      push_wr(0, 0, x0);
      send_byte(x0, $urandom_range(0, 4), 0);
      push_wr(0, 1, x1);
      send_byte(x1, 0, 1);
      m_err = 0;
    end
  endtask

  task automatic bad_cmd(input int b);
    tx_q.push_back(NAK_B);
    send_byte(b, 0, 0);
    m_err = 1;
  endtask

  task automatic partial(input bit is_w, input int k);
    int b;
    send_byte(is_w ? 8'h57 : 8'h58, $urandom_range(0, 4), 0);
    for (int i = 0; i < k; i++) begin
      b = $urandom_range(0, 255);
      push_wr(is_w ? 1 : 0, i, b);
      send_byte(b, $urandom_range(0, 4), 0);
    end
    wait_quiet(TO + 20);
    m_err = 1;
    if (is_w) m_loaded = 0;
  endtask

  initial begin
    int op;
    int b;
    int rel;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cont_state", int'(cont_state), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_start", int'(start), 0);
    check("rst_tx_start", int'(tx_start), 0);
    check("rst_tx_data", int'(tx_data), 0);
    rst_n = 1'b1;

    // X before W
    x_frame(8'h18, 8'h08, 0);
    wait_quiet(3);
    check_status();

    // Directed weight frame and compute
    w_frame(8'h10, 8'h20, 8'hF0);
    wait_quiet(3);
    check_status();
    x_frame(8'h18, 8'h08, 8'h10);
    wait_quiet(3);
    check_status();

    // Timeout inside a weight frame
    partial(1, 1);
    check_status();

    // Back-pressure: response held while tx_busy stays high; bytes dropped
    w_frame($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    wait_quiet(3);
    @(posedge clk);
    #1;
    hold_busy = 1;
    bad_cmd(8'h33);
    repeat (200) @(posedge clk);
    send_byte(8'h57, 0, 0);
    repeat (300) @(posedge clk);
    check("bp_held", tx_q.size(), 1);
    @(posedge clk);
    #1;
    rel = cyc;
    hold_busy = 0;
    wait_quiet(3);
    check("bp_tx_cycle", last_tx_cyc, rel + 1);
    check_status();

    // Randomized command mix
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: w_frame($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        1: x_frame($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        2: begin
          b = $urandom_range(0, 255);
          if (b == 8'h57 || b == 8'h58) b = 8'h00;
          bad_cmd(b);
        end
        3: partial(1, $urandom_range(0, NI));
        default: begin
          if (m_loaded) partial(0, $urandom_range(0, NI - 1));
          else bad_cmd(8'hFF);
        end
      endcase
      wait_quiet(3);
      check_status();
    end

    // Asynchronous reset while waiting for done
    w_frame(8'h01, 8'h02, 8'h03);
    wait_quiet(3);
    core_en = 0;
    x_frame(8'h11, 8'h22, 0);
    wait_quiet(5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cont_state", int'(cont_state), 0);
    check("arst_outputs", int'({wr_en, start, tx_start, wr_weight}), 0);
    check("arst_tx_data", int'(tx_data), 0);
    check("arst_wr_data", int'(wr_data), 0);
    m_loaded = 0;
    m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    done_req_n++;
    repeat (20) @(negedge clk);
    check("arst_done_ignored", tx_q.size() + st_q.size() + wr_q.size(), 0);
    check_status();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/perceptron_uart_ctrl.md
Name: perceptron_uart_ctrl

Overview:
Command sequencer between the UART byte interface and the perceptron datapath.
- Parses host command frames and loads weights, bias and inputs into the perceptron register file.
- Triggers a compute, waits for completion and returns the result byte over UART.
- Sits inside perceptron_top, between the uart rx/tx cores and the perceptron core.
- Drives the 5-bit cont_state status shown on the board LEDs.

Parameters:
DATA_W, 8, fixed-point word width (fp_integer_width + fp_fract_width).
N_INPUTS, 2, number of perceptron inputs; the weight frame carries N_INPUTS+1 words (weights, then bias).
TIMEOUT_CYCLES, 12000000, idle-byte timeout inside a frame (1 s at 12 MHz).

Ports:
clk  in  1  system clock.
rst_n  in  1  reset: asynchronous assert, active-low.
rx_data  in  DATA_W  received byte from the uart rx core.
rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
tx_data  out  DATA_W  byte to transmit.
tx_start  out  1  one-cycle transmit request.
tx_busy  in  1  uart tx core busy; asserted no later than 1 cycle after tx_start.
wr_en  out  1  register-file write strobe.
wr_weight  out  1  1 = weight/bias bank, 0 = input bank.
wr_sel  out  $clog2(N_INPUTS+1)  word index (index N_INPUTS = bias).
wr_data  out  DATA_W  word to write.
start  out  1  one-cycle compute trigger.
done  in  1  one-cycle completion strobe from the perceptron core.
result  in  DATA_W  perceptron output, valid while done=1.
cont_state  out  5  status: [2:0] FSM state code, [3] sticky error, [4] weights_loaded.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; index counter 0; weights_loaded=0; error=0.
- Command bytes (from package): CMD_W=0x57, CMD_X=0x58, ACK=0x06, NAK=0x15.
- State codes: IDLE=0, LOAD_W=1, LOAD_X=2, COMPUTE=3, WAIT_DONE=4, SEND=5, SEND_GUARD=6.
- IDLE, on rx_valid:
  - CMD_W -> LOAD_W, index=0.
  - CMD_X with weights_loaded=1 -> LOAD_X, index=0.
  - CMD_X with weights_loaded=0 -> SEND with tx_data=NAK; error set.
  - Any other byte -> SEND with tx_data=NAK; error set.
- LOAD_W, on each rx_valid:
  - Next cycle: wr_en=1, wr_weight=1, wr_sel=index, wr_data=byte; index increments.
  - After word N_INPUTS (the bias): weights_loaded=1; -> SEND with tx_data=ACK.
- LOAD_X, on each rx_valid:
  - Same as LOAD_W but wr_weight=0.
  - After word N_INPUTS-1 -> COMPUTE.
- COMPUTE: start=1 for exactly 1 cycle, i.e. 2 cycles after the last input byte's rx_valid; -> WAIT_DONE.
- WAIT_DONE: on done, latch result into tx_data -> SEND. No timeout applies here.
- SEND: wait until tx_busy=0, then tx_start=1 for 1 cycle -> SEND_GUARD.
- SEND_GUARD: 1 cycle, lets tx_busy assert -> IDLE.
- Timeout:
  - Counter clears on every rx_valid and runs only in LOAD_W/LOAD_X.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE, error set, partial frame discarded.
  - weights_loaded is unchanged by a timeout, but an aborted LOAD_W clears it (the weight bank is partially overwritten).
- Ignored events:
  - rx_valid in COMPUTE, WAIT_DONE, SEND or SEND_GUARD is dropped.
  - done outside WAIT_DONE is ignored.
- Error clears only on reset, or on a successful ACK/result transmission.
- Simultaneous timeout expiry and rx_valid: rx_valid wins; the byte is accepted and the counter clears.
- Reset mid-frame or mid-compute: immediate return to reset values. Any start already issued is not retracted.
- At most one pulse per cycle on each of wr_en, start and tx_start; these never overlap.

Decomposition:
- Package perceptron_ctrl_pkg holds:
  - state encoding (3-bit);
  - CMD_W, CMD_X, ACK, NAK;
  - a width helper for wr_sel.
- One natural sub-module: ctrl_timeout_counter, a loadable/clearable down-counter with an expiry pulse and an enable input.

Test Plan:
- Weight frame: rx 0x57, 0x10, 0x20, 0xF0 (N_INPUTS=2).
  - Required: three wr_en pulses with wr_weight=1, sel 0/1/2, data 0x10/0x20/0xF0.
  - Then tx_start with tx_data=0x06; cont_state[4]=1.
- Compute: after the weight frame, rx 0x58, 0x18, 0x08.
  - Required: two input writes, then start 2 cycles after the last rx_valid.
  - Drive done with result=0x10 -> tx_start with tx_data=0x10.
- X before W: from reset, rx 0x58 -> NAK 0x15 sent; cont_state[3]=1; no wr_en; no start.
- Timeout: rx 0x57, 0x10, then silence for TIMEOUT_CYCLES.
  - Required: return to IDLE, cont_state[3]=1, cont_state[4]=0, no ACK.
- Back-pressure: hold tx_busy=1 for 500 cycles at SEND.
  - Required: tx_start stays 0 until the cycle after tx_busy falls.
  - Bytes received meanwhile are dropped.
- Async reset: assert rst_n=0 in WAIT_DONE, then pulse done after release.
  - Required: all outputs 0 immediately on assert; the done pulse after release is ignored.
